// File: rtl/sysex_patch_dump.sv
// sysex_patch_dump: reads back one synth-engine bank over the shared parameter
// bus, one address at a time, and streams it out as a MIDI SysEx message.
// The message is F0, the manufacturer ID and the bank number, then two nibble
// bytes per address, a 7-bit checksum and F7. Bytes leave through a
// valid/ready handshake.
module sysex_patch_dump #(
    parameter int          NUM_BANKS = 4,
    parameter int          BANK_W    = 2,
    parameter int          ADR_FIRST = 0,
    parameter int          ADR_LAST  = 127,
    parameter int          READ_W    = 2,
    parameter logic [7:0]  MFR_ID    = 8'h7D
) (
    input  logic                 sCLK_XVXOSC,
    input  logic                 reset_data_N,
    input  logic                 dump_req,
    input  logic [BANK_W-1:0]    dump_bank,
    input  logic [7:0]           data,
    output logic [6:0]           adr,
    output logic                 read,
    output logic [NUM_BANKS-1:0] bank_sel,
    output logic                 sysex_data_patch_send,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int              RC_W        = (READ_W > 1) ? $clog2(READ_W) : 1;
    localparam logic [RC_W-1:0] RD_LAST     = RC_W'(READ_W - 1);
    localparam logic [6:0]      ADR_FIRST_C = 7'(ADR_FIRST);
    localparam logic [6:0]      ADR_LAST_C  = 7'(ADR_LAST);

    typedef enum logic [3:0] {
        S_IDLE, S_H0, S_H1, S_H2, S_SETUP, S_RD, S_HOLD, S_CAP,
        S_TXH, S_TXL, S_CKS, S_EOX, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [6:0]            adr_q, adr_d;
    logic                  read_q, read_d;
    logic [NUM_BANKS-1:0]  bank_sel_q, bank_sel_d;
    logic                  send_q, send_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [6:0]            chk_q, chk_d;
    logic [BANK_W-1:0]     bank_q, bank_d;
    logic [7:0]            byte_q, byte_d;
    logic [RC_W-1:0]       rd_cnt_q, rd_cnt_d;

    // A byte is consumed only when it is actually on offer.
    logic hs;
    assign hs = tx_valid_q & tx_ready;

    // One-hot decode of the latched bank. An out-of-range bank selects nothing.
    logic [NUM_BANKS-1:0] onehot;
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_sel
        assign onehot[gi] = (bank_q == BANK_W'(gi));
    end

    // State and datapath registers; reset drops everything immediately.
    always_ff @(posedge sCLK_XVXOSC or negedge reset_data_N) begin
        if (!reset_data_N) begin
            state_q    <= S_IDLE;
            adr_q      <= '0;
            read_q     <= 1'b0;
            bank_sel_q <= '0;
            send_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            chk_q      <= '0;
            bank_q     <= '0;
            byte_q     <= '0;
            rd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            read_q     <= read_d;
            bank_sel_q <= bank_sel_d;
            send_q     <= send_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            chk_q      <= chk_d;
            bank_q     <= bank_d;
            byte_q     <= byte_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    // Next-state: emitting states wait for the handshake, bus states are timed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (dump_req) state_d = S_H0;
            S_H0:    if (hs) state_d = S_H1;
            S_H1:    if (hs) state_d = S_H2;
            S_H2:    if (hs) state_d = S_SETUP;
            S_SETUP: state_d = S_RD;
            S_RD:    if (rd_cnt_q == RD_LAST) state_d = S_HOLD;
            S_HOLD:  state_d = S_CAP;
            S_CAP:   state_d = S_TXH;
            S_TXH:   if (hs) state_d = S_TXL;
            S_TXL:   if (hs) state_d = (adr_q == ADR_LAST_C) ? S_CKS : S_SETUP;
            S_CKS:   if (hs) state_d = S_EOX;
            S_EOX:   if (hs) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they register in step with it.
    always_comb begin
        adr_d      = adr_q;
        read_d     = (state_d == S_RD);
        bank_sel_d = bank_sel_q;
        send_d     = send_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        chk_d      = chk_q;
        bank_d     = bank_q;
        byte_d     = byte_q;
        rd_cnt_d   = (state_q == S_RD) ? rd_cnt_q + RC_W'(1) : '0;

        if (state_q == S_IDLE && dump_req) begin
            bank_d = dump_bank;
            adr_d  = ADR_FIRST_C;
            chk_d  = '0;
        end

        // The bus has been settled for a full clock after the strobe fell.
        if (state_q == S_CAP) begin
            byte_d = data;
        end

        if (hs && state_q == S_TXH) begin
            chk_d = chk_q + {3'b000, byte_q[7:4]};
        end

        // The address only moves once the low nibble has gone; the last one is terminal.
        if (hs && state_q == S_TXL) begin
            chk_d = chk_q + {3'b000, byte_q[3:0]};
            if (adr_q != ADR_LAST_C) begin
                adr_d = adr_q + 7'd1;
            end
        end

        // Select and send stay up across consecutive addresses, drop once for the checksum.
        if (state_d == S_SETUP) begin
            bank_sel_d = onehot;
            send_d     = 1'b1;
        end else if (state_d == S_CKS) begin
            bank_sel_d = '0;
            send_d     = 1'b0;
        end

        case (state_d)
            S_H0:  begin tx_data_d = 8'hF0;                      tx_valid_d = 1'b1; end
            S_H1:  begin tx_data_d = MFR_ID;                     tx_valid_d = 1'b1; end
            S_H2:  begin tx_data_d = 8'(bank_q) & 8'h7F;         tx_valid_d = 1'b1; end
            S_TXH: begin tx_data_d = {4'h0, byte_d[7:4]};        tx_valid_d = 1'b1; end
            S_TXL: begin tx_data_d = {4'h0, byte_q[3:0]};        tx_valid_d = 1'b1; end
            S_CKS: begin tx_data_d = {1'b0, 7'd0 - chk_d};       tx_valid_d = 1'b1; end
            S_EOX: begin tx_data_d = 8'hF7;                      tx_valid_d = 1'b1; end
            default: ;
        endcase
    end

    assign adr                   = adr_q;
    assign read                  = read_q;
    assign bank_sel              = bank_sel_q;
    assign sysex_data_patch_send = send_q;
    assign tx_data               = tx_data_q;
    assign tx_valid              = tx_valid_q;
    assign busy                  = busy_q;
    assign done                  = done_q;

endmodule

// File: tb/tb_sysex_patch_dump.sv
// Bench for sysex_patch_dump: a 16-address instance with a 3-clock strobe and
// a single-address instance parked at 127.
`timescale 1ns/1ps
module tb_sysex_patch_dump;

    localparam int RW0 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    // instance 0: addresses 0..15, READ_W=3
    logic       req0, txr0, read0, send0, txv0, busy0, done0;
    logic [1:0] bank0;
    logic [7:0] data0, txd0;
    logic [6:0] adr0;
    logic [3:0] sel0;
    // instance 1: address 127 only
    logic       req1, txr1, read1, send1, txv1, busy1, done1;
    logic [1:0] bank1;
    logic [7:0] data1, txd1;
    logic [6:0] adr1;
    logic [3:0] sel1;

    sysex_patch_dump #(.NUM_BANKS(4), .BANK_W(2), .ADR_FIRST(0), .ADR_LAST(15),
                       .READ_W(RW0), .MFR_ID(8'h7D)) dut0 (
        .sCLK_XVXOSC(clk), .reset_data_N(rst_n), .dump_req(req0), .dump_bank(bank0),
        .data(data0), .adr(adr0), .read(read0), .bank_sel(sel0),
        .sysex_data_patch_send(send0), .tx_data(txd0), .tx_valid(txv0),
        .tx_ready(txr0), .busy(busy0), .done(done0));

    sysex_patch_dump #(.NUM_BANKS(4), .BANK_W(2), .ADR_FIRST(127), .ADR_LAST(127),
                       .READ_W(2), .MFR_ID(8'h7D)) dut1 (
        .sCLK_XVXOSC(clk), .reset_data_N(rst_n), .dump_req(req1), .dump_bank(bank1),
        .data(data1), .adr(adr1), .read(read1), .bank_sel(sel1),
        .sysex_data_patch_send(send1), .tx_data(txd1), .tx_valid(txv1),
        .tx_ready(txr1), .busy(busy1), .done(done1));

    // Model slave: drives one value at one address when selected, else zero.
    logic [6:0] slv_adr;
    logic [7:0] slv_val;
    logic [3:0] slv_sel;
    assign data0 = (send0 && sel0 == slv_sel && adr0 == slv_adr) ? slv_val : 8'h00;
    assign data1 = send1 ? 8'hFF : 8'h00;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Monitor for instance 0: byte log, strobe timing, select legality, done pulses.
    logic [7:0] stream [0:511];
    int nbytes = 0, done_cnt = 0, rd_rises = 0, rd_len_err = 0, rd_setup_err = 0, sel_err = 0;
    int rd_run = 0;
    logic       prev_read = 1'b0, prev_send = 1'b0;
    logic [6:0] prev_adr = '0;
    logic [3:0] prev_sel = '0;

    always @(negedge clk) begin
        if (txv0 && txr0) begin
            if (nbytes < 512) stream[nbytes] <= txd0;
            nbytes <= nbytes + 1;
        end
        if (read0) begin
            rd_run <= rd_run + 1;
        end else begin
            if (prev_read && rd_run != RW0) rd_len_err <= rd_len_err + 1;
            rd_run <= 0;
        end
        if (read0 && !prev_read) begin
            rd_rises <= rd_rises + 1;
            if (!(adr0 == prev_adr && sel0 == prev_sel && send0 && prev_send))
                rd_setup_err <= rd_setup_err + 1;
        end else if ((read0 || prev_read) && (adr0 != prev_adr || sel0 != prev_sel || !send0)) begin
            rd_setup_err <= rd_setup_err + 1;
        end
        if (send0 ? (sel0 != slv_sel) : (sel0 != 4'b0000)) sel_err <= sel_err + 1;
        if (done0) done_cnt <= done_cnt + 1;
        prev_read <= read0;
        prev_send <= send0;
        prev_adr  <= adr0;
        prev_sel  <= sel0;
    end

    int b_n, b_done, b_rises, b_len, b_setup, b_sel;

    task automatic take_base();
        b_n = nbytes; b_done = done_cnt; b_rises = rd_rises;
        b_len = rd_len_err; b_setup = rd_setup_err; b_sel = sel_err;
    endtask

    task automatic start0(input logic [1:0] bank);
        @(posedge clk); #1; bank0 = bank; req0 = 1'b1;
        @(posedge clk); #1; req0 = 1'b0;
    endtask

    task automatic wait_done0(input string name);
        int n = 0;
        int d = done_cnt;
        while (done_cnt == d && n < 3000) begin @(negedge clk); n++; end
        check($sformatf("%s done_seen", name), (done_cnt != d), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_stream(input string name, input int base, input logic [7:0] h2,
                                input logic [6:0] sadr, input logic [7:0] sval,
                                input logic [7:0] cks);
        logic [7:0] b;
        logic [6:0] sum;
        check($sformatf("%s count", name), nbytes - base, 37);
        check($sformatf("%s H0", name), stream[base],     8'hF0);
        check($sformatf("%s H1", name), stream[base + 1], 8'h7D);
        check($sformatf("%s H2", name), stream[base + 2], h2);
        for (int a = 0; a < 16; a++) begin
            b = (a == int'(sadr)) ? sval : 8'h00;
            check($sformatf("%s adr%0d hi", name, a), stream[base + 3 + 2 * a],     {4'h0, b[7:4]});
            check($sformatf("%s adr%0d lo", name, a), stream[base + 4 + 2 * a],     {4'h0, b[3:0]});
        end
        check($sformatf("%s CKS", name), stream[base + 35], cks);
        check($sformatf("%s EOX", name), stream[base + 36], 8'hF7);
        sum = '0;
        for (int i = 3; i < 36; i++) sum = sum + stream[base + i][6:0];
        check($sformatf("%s sum_mod128", name), sum, 0);
    endtask

    task automatic check_stats(input string name);
        check($sformatf("%s done_pulses", name), done_cnt - b_done, 1);
        check($sformatf("%s read_strobes", name), rd_rises - b_rises, 16);
        check($sformatf("%s read_len_err", name), rd_len_err - b_len, 0);
        check($sformatf("%s bus_hold_err", name), rd_setup_err - b_setup, 0);
        check($sformatf("%s bank_sel_err", name), sel_err - b_sel, 0);
        check($sformatf("%s idle_busy", name), {busy0, txv0, send0}, 3'b000);
    endtask

    typedef struct {
        logic [1:0] bank;
        logic [6:0] sadr;
        logic [7:0] sval;
        logic [3:0] sel;
        logic [7:0] h2;
        logic [7:0] cks;
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] exp1 [7];
    logic [7:0] got1 [8];

    initial begin
        int n, k, bad, dones, f7s;

        vecs[0] = '{2'd0, 7'd6,  8'hA5, 4'b0001, 8'h00, 8'h71};
        vecs[1] = '{2'd2, 7'd0,  8'h7E, 4'b0100, 8'h02, 8'h6B};
        vecs[2] = '{2'd3, 7'd15, 8'hFF, 4'b1000, 8'h03, 8'h62};
        vecs[3] = '{2'd1, 7'd3,  8'h00, 4'b0010, 8'h01, 8'h00};
        exp1[0] = 8'hF0; exp1[1] = 8'h7D; exp1[2] = 8'h02; exp1[3] = 8'h0F;
        exp1[4] = 8'h0F; exp1[5] = 8'h62; exp1[6] = 8'hF7;

        rst_n = 1'b0;
        req0 = 1'b0; bank0 = 2'd0; txr0 = 1'b1;
        req1 = 1'b0; bank1 = 2'd0; txr1 = 1'b1;
        slv_adr = 7'd6; slv_val = 8'hA5; slv_sel = 4'b0001;

        repeat (3) @(posedge clk); #1;
        check("reset dut0", {adr0, read0, sel0, send0, txd0, txv0, busy0, done0}, 0);
        check("reset dut1", {adr1, read1, sel1, send1, txd1, txv1, busy1, done1}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Full dumps from the vector table, tx_ready tied high.
        for (int v = 0; v < 4; v++) begin
            slv_adr = vecs[v].sadr; slv_val = vecs[v].sval; slv_sel = vecs[v].sel;
            take_base();
            start0(vecs[v].bank);
            check($sformatf("vec%0d accept", v), {busy0, adr0}, {1'b1, 7'd0});
            wait_done0($sformatf("vec%0d", v));
            check_stream($sformatf("vec%0d", v), b_n, vecs[v].h2, vecs[v].sadr,
                         vecs[v].sval, vecs[v].cks);
            check_stats($sformatf("vec%0d", v));
        end

        // Backpressure on the first data nibble, plus a request for bank 3 while busy.
        slv_adr = 7'd0; slv_val = 8'hA5; slv_sel = 4'b0001;
        take_base();
        start0(2'd0);
        n = 0;
        while (nbytes - b_n < 3 && n < 100) begin @(negedge clk); n++; end
        check("bp header_sent", (nbytes - b_n >= 3), 1);
        @(posedge clk); #1; txr0 = 1'b0; bank0 = 2'd3; req0 = 1'b1;
        @(posedge clk); #1; req0 = 1'b0;
        n = 0;
        while (!txv0 && n < 30) begin @(negedge clk); n++; end
        check("bp first_nibble", {txv0, txd0, adr0}, {1'b1, 8'h0A, 7'd0});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp stall%0d", i), {txv0, txd0, adr0}, {1'b1, 8'h0A, 7'd0});
            check($sformatf("bp stall%0d bytes", i), nbytes - b_n, 3);
        end
        @(posedge clk); #1; txr0 = 1'b1;
        wait_done0("bp");
        check_stream("bp", b_n, 8'h00, 7'd0, 8'hA5, 8'h71);
        check_stats("bp");

        // Reset asserted while address 8 is on the bus.
        slv_adr = 7'd6; slv_val = 8'hA5; slv_sel = 4'b0001;
        take_base();
        start0(2'd0);
        n = 0;
        while (adr0 != 7'd8 && n < 500) begin @(negedge clk); n++; end
        check("rst reached_adr8", adr0, 7'd8);
        rst_n = 1'b0;
        #1;
        check("rst async_outputs", {adr0, read0, sel0, send0, txd0, txv0, busy0, done0}, 0);
        repeat (3) @(posedge clk); #1;
        f7s = 0;
        for (int i = b_n; i < nbytes; i++) if (stream[i] == 8'hF7) f7s++;
        check("rst no_eox", f7s, 0);
        check("rst held_quiet", {txv0, busy0, done0}, 3'b000);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        take_base();
        start0(2'd0);
        wait_done0("restart");
        check_stream("restart", b_n, 8'h00, 7'd6, 8'hA5, 8'h71);
        check_stats("restart");

        // Single-address instance parked at 127.
        @(posedge clk); #1; bank1 = 2'd2; req1 = 1'b1;
        @(posedge clk); #1; req1 = 1'b0;
        k = 0; bad = 0; dones = 0; n = 0;
        while (dones == 0 && n < 200) begin
            @(negedge clk);
            n++;
            if (txv1 && txr1) begin
                if (k < 8) got1[k] = txd1;
                k++;
            end
            if (busy1 && adr1 != 7'd127) bad++;
            if (done1) dones++;
        end
        check("a127 done_seen", dones, 1);
        check("a127 count", k, 7);
        for (int i = 0; i < 7; i++) check($sformatf("a127 byte%0d", i), got1[i], exp1[i]);
        check("a127 adr_while_busy", bad, 0);
        repeat (3) @(negedge clk);
        check("a127 adr_after", {adr1, busy1, send1, sel1}, {7'd127, 1'b0, 1'b0, 4'b0000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
